// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decode-to-sequencer control and PC/stack status bundle
interface pc_sequencer_if #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
);
  logic                         en;
  logic                         stall;
  logic [1:0]                   op;
  logic [WIDTH-1:0]             target;
  logic [WIDTH-1:0]             pc;
  logic [$clog2(STACK_DEPTH):0] depth;
  logic                         stk_full;
  logic                         stk_empty;
  logic                         err;

  modport master (
    output en, stall, op, target,
    input  pc, depth, stk_full, stk_empty, err
  );

  modport slave (
    input  en, stall, op, target,
    output pc, depth, stk_full, stk_empty, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer with return-address stack; PC_SEQ_REL_JUMP_EN selects pc-relative JUMP/CALL
module pc_sequencer #(
  parameter int WIDTH       = 8,
  parameter int STEP        = 4,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave sq
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);
  localparam logic [DW-1:0]    FULL_D  = DW'(STACK_DEPTH);
  localparam logic [DW-1:0]    ONE_D   = DW'(1);

  typedef enum logic [1:0] {OP_INC = 2'b00, OP_JUMP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11} op_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             full_q, empty_q;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  logic             adv;
  logic             push;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] dest_pc;
  logic [DW-1:0]    depth_m1;
  logic [WIDTH-1:0] top;

  assign adv      = sq.en & ~sq.stall;
  assign seq_pc   = pc_q + STEP_W;
  assign depth_m1 = depth_q - ONE_D;
  assign top      = stack_q[depth_m1[AW-1:0]];
`ifdef PC_SEQ_REL_JUMP_EN
  // Two's-complement offset: modulo addition handles negative targets.
  assign dest_pc  = pc_q + sq.target;
`else
  assign dest_pc  = sq.target;
`endif

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    push    = 1'b0;
    if (adv) begin
      case (op_e'(sq.op))
        OP_INC:  pc_d = seq_pc;
        OP_JUMP: pc_d = dest_pc;
        OP_CALL: begin
          if (full_q) begin
            pc_d  = seq_pc;
            err_d = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = dest_pc;
            depth_d = depth_q + ONE_D;
          end
        end
        OP_RET: begin
          if (empty_q) begin
            pc_d  = seq_pc;
            err_d = 1'b1;
          end else begin
            pc_d    = top;
            depth_d = depth_m1;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  // Flags are registered from depth_d so they always track depth_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_W;
      depth_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      full_q  <= (depth_d == FULL_D);
      empty_q <= (depth_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack_q[depth_q[AW-1:0]] <= seq_pc;
    end
  end

  assign sq.pc        = pc_q;
  assign sq.depth     = depth_q;
  assign sq.stk_full  = full_q;
  assign sq.stk_empty = empty_q;
  assign sq.err       = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector table plus randomized model check for pc_sequencer
module tb_pc_sequencer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_sequencer_if #(.WIDTH(8), .STACK_DEPTH(4)) sq ();

  pc_sequencer #(.WIDTH(8), .STEP(4), .RESET_VEC(0), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       stall;
    logic [1:0] op;
    logic [7:0] dest;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       err;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic e, input logic s, input logic [1:0] o,
                     input logic [7:0] d, input logic [7:0] p, input logic [2:0] dp, input logic er);
    vec_t v;
    v.rst_n = r; v.en = e; v.stall = s; v.op = o; v.dest = d;
    v.pc = p; v.depth = dp; v.err = er;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] p, input int dp, input logic er);
    chk({tag, ".pc"}, int'(sq.pc), int'(p));
    chk({tag, ".depth"}, int'(sq.depth), dp);
    chk({tag, ".full"}, int'(sq.stk_full), int'(dp == 4));
    chk({tag, ".empty"}, int'(sq.stk_empty), int'(dp == 0));
    chk({tag, ".err"}, int'(sq.err), int'(er));
  endtask

  // Table rows name the desired destination; the relative build needs it as an offset.
  function automatic logic [7:0] tgt_for(input logic [7:0] dest, input logic [7:0] cur);
`ifdef PC_SEQ_REL_JUMP_EN
    return dest - cur;
`else
    return dest;
`endif
  endfunction

  localparam logic [1:0] INC = 2'b00, JMP = 2'b01, CALL = 2'b10, RET = 2'b11;

  int unsigned m_pc;
  logic [7:0]  m_stk[$];
  bit          m_err;
  logic [7:0]  prev_pc;
  logic [7:0]  tg;
  logic [7:0]  m_dest;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; sq.en = 1'b0; sq.stall = 1'b0; sq.op = INC; sq.target = '0;

    add(0,0,0,INC , 8'h00, 8'h00,0,0);
    add(1,1,0,INC , 8'h00, 8'h04,0,0);
    add(1,1,0,INC , 8'h00, 8'h08,0,0);
    add(1,1,0,INC , 8'h00, 8'h0C,0,0);
    add(1,1,1,INC , 8'h00, 8'h0C,0,0);
    add(1,1,1,CALL, 8'h90, 8'h0C,0,0);
    add(1,0,0,RET , 8'h00, 8'h0C,0,0);
    add(1,1,0,JMP , 8'hFC, 8'hFC,0,0);
    add(1,1,0,INC , 8'h00, 8'h00,0,0);
    add(1,1,0,JMP , 8'h10, 8'h10,0,0);
    add(1,1,0,CALL, 8'h80, 8'h80,1,0);
    add(1,1,0,RET , 8'h00, 8'h14,0,0);
    add(1,1,0,JMP , 8'h00, 8'h00,0,0);
    add(1,1,0,CALL, 8'h20, 8'h20,1,0);
    add(1,1,0,CALL, 8'h30, 8'h30,2,0);
    add(1,1,0,CALL, 8'h40, 8'h40,3,0);
    add(1,1,0,CALL, 8'h50, 8'h50,4,0);
    add(1,1,0,CALL, 8'h60, 8'h54,4,1);
    add(1,1,0,RET , 8'h00, 8'h44,3,1);
    add(1,1,0,RET , 8'h00, 8'h34,2,1);
    add(1,1,0,RET , 8'h00, 8'h24,1,1);
    add(1,1,0,RET , 8'h00, 8'h04,0,1);
    add(0,0,0,INC , 8'h00, 8'h00,0,0);
    add(1,1,0,JMP , 8'h08, 8'h08,0,0);
    add(1,1,0,RET , 8'h00, 8'h0C,0,1);
    add(1,1,0,INC , 8'h00, 8'h10,0,1);
    add(1,1,0,JMP , 8'h20, 8'h20,0,1);
    add(0,1,0,JMP , 8'h99, 8'h00,0,0);

    prev_pc = 8'h00;
    for (int i = 0; i < vt.size(); i++) begin
      rst_n     = vt[i].rst_n;
      sq.en     = vt[i].en;
      sq.stall  = vt[i].stall;
      sq.op     = vt[i].op;
      sq.target = tgt_for(vt[i].dest, prev_pc);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vt[i].pc, int'(vt[i].depth), vt[i].err);
      prev_pc = vt[i].pc;
    end

    // Same raw stimulus gives a different pc per build.
    rst_n = 1'b1; sq.en = 1'b1; sq.stall = 1'b0;
    sq.op = JMP; sq.target = 8'h40;
    @(posedge clk); #1;
    chk("rel_pre.pc", int'(sq.pc), 32'h40);
    sq.target = 8'hF0;
    @(posedge clk); #1;
`ifdef PC_SEQ_REL_JUMP_EN
    chk("rel_jump.pc", int'(sq.pc), 32'h30);
`else
    chk("abs_jump.pc", int'(sq.pc), 32'hF0);
`endif

    m_pc = 0; m_err = 0; m_stk.delete();
    for (int i = 0; i < 600; i++) begin
      rst_n     = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
      sq.en     = ($urandom_range(0, 9) != 0);
      sq.stall  = ($urandom_range(0, 5) == 0);
      sq.op     = 2'($urandom_range(0, 3));
      tg        = 8'($urandom);
      sq.target = tg;
`ifdef PC_SEQ_REL_JUMP_EN
      m_dest = 8'((m_pc + tg) % 256);
`else
      m_dest = tg;
`endif
      if (!rst_n) begin
        m_pc = 0; m_err = 0; m_stk.delete();
      end else if (sq.en && !sq.stall) begin
        case (sq.op)
          INC: m_pc = (m_pc + 4) % 256;
          JMP: m_pc = m_dest;
          CALL: begin
            if (m_stk.size() == 4) begin
              m_err = 1; m_pc = (m_pc + 4) % 256;
            end else begin
              m_stk.push_back(8'((m_pc + 4) % 256));
              m_pc = m_dest;
            end
          end
          default: begin
            if (m_stk.size() == 0) begin
              m_err = 1; m_pc = (m_pc + 4) % 256;
            end else begin
              m_pc = m_stk.pop_back();
            end
          end
        endcase
      end
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", i), 8'(m_pc), m_stk.size(), m_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
